// File: rtl/sprite_palette_pkg.sv
// Shared types and constants for the sprite palette bank.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sprite_palette_pkg;

    localparam int unsigned PAL_CH_W    = 4;
    localparam int unsigned PAL_IDX_W   = 4;
    localparam int unsigned PAL_ENTRIES = 2**PAL_IDX_W;
    localparam int unsigned FLASH_CNT_W = 8;

    typedef struct packed {
        logic [PAL_CH_W-1:0] r;
        logic [PAL_CH_W-1:0] g;
        logic [PAL_CH_W-1:0] b;
    } rgb_t;

    // Index 0 is the magenta colour key; the rest is a grey, purple and blue ramp.
    localparam rgb_t DEFAULT_PALETTE [PAL_ENTRIES] = '{
        12'hF0F, 12'h222, 12'h555, 12'h888,
        12'hBBB, 12'h305, 12'h508, 12'h70A,
        12'h90C, 12'hB4E, 12'h004, 12'h008,
        12'h00C, 12'h00F, 12'h48F, 12'hFFF
    };

endpackage

// File: rtl/sprite_flash_ctrl.sv
// Frame-counted hit-flash timer: trigger loads the count, frame_start decrements it.
// Latency: flash_active is registered and tracks the counter value held after each edge.
// Backpressure: none; pulses are consumed every cycle.
module sprite_flash_ctrl
    import sprite_palette_pkg::*;
#(
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_start,
    input  logic flash_trig,
    output logic flash_active
);

    localparam logic [FLASH_CNT_W-1:0] LOAD = FLASH_FRAMES[FLASH_CNT_W-1:0];

    logic [FLASH_CNT_W-1:0] cnt;
    logic [FLASH_CNT_W-1:0] cnt_nxt;

    // A trigger always wins over a coincident frame tick so a retrigger restarts the full count.
    always_comb begin
        cnt_nxt = cnt;
        if (flash_trig) begin
            cnt_nxt = LOAD;
        end else if (frame_start && (cnt != '0)) begin
            cnt_nxt = cnt - FLASH_CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt          <= '0;
            flash_active <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            flash_active <= (cnt_nxt != '0) && cnt_nxt[0];
        end
    end

endmodule

// File: rtl/sprite_palette_bank.sv
// Multi-bank programmable sprite palette with key transparency and hit-flash override.
// Latency: fixed 2 cycles from pix_valid to out_valid, one lookup per cycle.
// Backpressure: none; the pipeline never stalls and outputs hold while out_valid is low.
module sprite_palette_bank
    import sprite_palette_pkg::*;
#(
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned CH_W         = 4,
    parameter int unsigned NUM_BANKS    = 4,
    parameter int unsigned KEY_INDEX    = 0,
    parameter int unsigned FLASH_FRAMES = 8,
    parameter logic [3*CH_W-1:0] FLASH_RGB = '1,
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pix_valid,
    input  logic [IDX_W-1:0]  pix_idx,
    input  logic [BANK_W-1:0] pix_bank,
    input  logic              wr_en,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [3*CH_W-1:0] wr_rgb,
    input  logic              frame_start,
    input  logic              flash_trig,
    output logic              out_valid,
    output logic [CH_W-1:0]   red,
    output logic [CH_W-1:0]   green,
    output logic [CH_W-1:0]   blue,
    output logic              out_transparent,
    output logic              flash_active
);

    localparam int unsigned       ENTRIES = 2**IDX_W;
    localparam int unsigned       RGB_W   = 3*CH_W;
    localparam logic [BANK_W:0]   NB      = NUM_BANKS[BANK_W:0];
    localparam logic [IDX_W-1:0]  KEY     = KEY_INDEX[IDX_W-1:0];

    function automatic logic [RGB_W-1:0] default_rgb(input int unsigned i);
        rgb_t e;
        e = DEFAULT_PALETTE[i[PAL_IDX_W-1:0]];
        return {CH_W'(e.r), CH_W'(e.g), CH_W'(e.b)};
    endfunction

    logic [RGB_W-1:0] pal [NUM_BANKS][ENTRIES];

    logic             wr_ok;
    logic             rd_ok;
    logic [RGB_W-1:0] rd_rgb;

    logic             s1_vld;
    logic [IDX_W-1:0] s1_idx;
    logic             s1_bank_ok;
    logic [RGB_W-1:0] s1_rgb;
    logic             s1_transp;

    logic [RGB_W-1:0] out_rgb;

    assign wr_ok = ({1'b0, wr_bank} < NB);
    assign rd_ok = ({1'b0, pix_bank} < NB);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    pal[b][i] <= default_rgb(i);
                end else if (wr_en && wr_ok &&
                             (wr_bank == BANK_W'(b)) && (wr_idx == IDX_W'(i))) begin
                    pal[b][i] <= wr_rgb;
                end
            end
        end
    end

    always_comb begin
        rd_rgb = '0;
        if (rd_ok) begin
            rd_rgb = pal[pix_bank][pix_idx];
        end
    end

    // Stage 1 captures pre-edge array contents, so a same-cycle write is not yet visible.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_vld     <= 1'b0;
            s1_idx     <= '0;
            s1_bank_ok <= 1'b0;
            s1_rgb     <= '0;
        end else begin
            s1_vld <= pix_valid;
            if (pix_valid) begin
                s1_idx     <= pix_idx;
                s1_bank_ok <= rd_ok;
                s1_rgb     <= rd_rgb;
            end
        end
    end

    assign s1_transp = (s1_idx == KEY) || !s1_bank_ok;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid       <= 1'b0;
            out_transparent <= 1'b0;
            out_rgb         <= '0;
        end else begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_transparent <= s1_transp;
                if (s1_transp) begin
                    out_rgb <= '0;
                end else if (flash_active) begin
                    out_rgb <= FLASH_RGB;
                end else begin
                    out_rgb <= s1_rgb;
                end
            end
        end
    end

    assign {red, green, blue} = out_rgb;

    sprite_flash_ctrl #(
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_flash (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_start  (frame_start),
        .flash_trig   (flash_trig),
        .flash_active (flash_active)
    );

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Self-checking bench for sprite_palette_bank: vector table, flash/reset sequences, random stream.
// Latency: outputs scored 2 cycles after each request.
// Backpressure: n/a.
module tb_sprite_palette_bank;

    localparam int NB = 5;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pix_valid;
    logic [3:0]  pix_idx;
    logic [2:0]  pix_bank;
    logic        wr_en;
    logic [2:0]  wr_bank;
    logic [3:0]  wr_idx;
    logic [11:0] wr_rgb;
    logic        frame_start;
    logic        flash_trig;
    logic        out_valid;
    logic [3:0]  red, green, blue;
    logic        out_transparent;
    logic        flash_active;

    sprite_palette_bank #(
        .IDX_W(4), .CH_W(4), .NUM_BANKS(NB), .KEY_INDEX(0),
        .FLASH_FRAMES(8), .FLASH_RGB(12'hFFF)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .pix_valid(pix_valid), .pix_idx(pix_idx), .pix_bank(pix_bank),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx), .wr_rgb(wr_rgb),
        .frame_start(frame_start), .flash_trig(flash_trig),
        .out_valid(out_valid), .red(red), .green(green), .blue(blue),
        .out_transparent(out_transparent), .flash_active(flash_active)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        t;
        logic [11:0] rgb;
        int          ecyc;
        string       nm;
    } exp_t;

    typedef struct {
        bit          lk;
        logic [2:0]  lb;
        logic [3:0]  li;
        bit          wr;
        logic [2:0]  wb;
        logic [3:0]  wi;
        logic [11:0] wd;
        logic        et;
        logic [11:0] erg;
        string       nm;
    } vec_t;

    exp_t        q[$];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          fcnt;
    logic [11:0] dflt [16];
    logic [11:0] mpal [NB][16];
    vec_t        tv [15];
    bit          exp_fa [9];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic void model_reset();
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < 16; i++)
                mpal[b][i] = dflt[i];
        fcnt = 0;
    endfunction

    // Drives one cycle of stimulus and pushes the expected lookup result.
    task automatic step(input bit lk, input logic [2:0] lb, input logic [3:0] li,
                        input bit wr, input logic [2:0] wb, input logic [3:0] wi,
                        input logic [11:0] wd, input bit trig, input bit fs,
                        input bit use_model, input logic et, input logic [11:0] erg,
                        input string nm);
        exp_t e;
        @(posedge Clk); #1;
        pix_valid = lk; pix_bank = lb; pix_idx = li;
        wr_en = wr; wr_bank = wb; wr_idx = wi; wr_rgb = wd;
        flash_trig = trig; frame_start = fs;
        if (trig) fcnt = 8;
        else if (fs && fcnt != 0) fcnt--;
        if (lk) begin
            if (use_model) begin
                e.t = 1'b0;
                if (li == 4'd0 || int'(lb) >= NB) begin
                    e.t = 1'b1; e.rgb = 12'h000;
                end else if (fcnt % 2 == 1) begin
                    e.rgb = 12'hFFF;
                end else begin
                    e.rgb = mpal[lb][li];
                end
            end else begin
                e.t = et; e.rgb = erg;
            end
            e.ecyc = cyc + 2;
            e.nm = nm;
            q.push_back(e);
        end
        if (wr && int'(wb) < NB) mpal[wb][wi] = wd;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    endtask

    task automatic look(input logic [2:0] lb, input logic [3:0] li, input string nm);
        step(1, lb, li, 0, 0, 0, 0, 0, 0, 1, 0, 0, nm);
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (Reset_n === 1'b1 && out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 0);
            end else begin
                e = q.pop_front();
                chk({e.nm, "_transp"}, 32'(out_transparent), 32'(e.t));
                chk({e.nm, "_rgb"}, 32'({red, green, blue}), 32'(e.rgb));
                chk({e.nm, "_latency"}, cyc, e.ecyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        dflt = '{12'hF0F, 12'h222, 12'h555, 12'h888, 12'hBBB, 12'h305, 12'h508, 12'h70A,
                 12'h90C, 12'hB4E, 12'h004, 12'h008, 12'h00C, 12'h00F, 12'h48F, 12'hFFF};
        exp_fa = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
        //        lk lb li wr wb wi wd       et erg      name
        tv[0]  = '{1, 0, 1, 0, 0, 0, 12'h000, 0, 12'h222, "idx1_b0"};
        tv[1]  = '{1, 2, 5, 1, 2, 5, 12'h9A3, 0, 12'h305, "wr_same_cycle"};
        tv[2]  = '{1, 2, 5, 0, 0, 0, 12'h000, 0, 12'h9A3, "wr_next_cycle"};
        tv[3]  = '{1, 3, 0, 0, 0, 0, 12'h000, 1, 12'h000, "key_idx"};
        tv[4]  = '{1, 5, 3, 0, 0, 0, 12'h000, 1, 12'h000, "illegal_bank"};
        tv[5]  = '{0, 0, 0, 1, 5, 7, 12'h123, 0, 12'h000, "wr_bad_bank"};
        tv[6]  = '{1, 0, 7, 0, 0, 0, 12'h000, 0, 12'h70A, "nowr_b0"};
        tv[7]  = '{1, 1, 7, 0, 0, 0, 12'h000, 0, 12'h70A, "nowr_b1"};
        tv[8]  = '{1, 2, 7, 0, 0, 0, 12'h000, 0, 12'h70A, "nowr_b2"};
        tv[9]  = '{1, 3, 7, 0, 0, 0, 12'h000, 0, 12'h70A, "nowr_b3"};
        tv[10] = '{1, 4, 7, 0, 0, 0, 12'h000, 0, 12'h70A, "nowr_b4"};
        tv[11] = '{1, 4, 10, 0, 0, 0, 12'h000, 0, 12'h004, "b4_idx10"};
        tv[12] = '{1, 1, 15, 1, 1, 3, 12'hABC, 0, 12'hFFF, "b1_idx15"};
        tv[13] = '{1, 7, 0, 0, 0, 0, 12'h000, 1, 12'h000, "bank7_key"};
        tv[14] = '{1, 1, 3, 0, 0, 0, 12'h000, 0, 12'hABC, "b1_idx3_new"};

        Reset_n = 1'b0;
        pix_valid = 0; pix_idx = 0; pix_bank = 0;
        wr_en = 0; wr_bank = 0; wr_idx = 0; wr_rgb = 0;
        frame_start = 0; flash_trig = 0;
        model_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_rgb", 32'({red, green, blue}), 0);
        chk("rst_transp", 32'(out_transparent), 0);
        chk("rst_flash", 32'(flash_active), 0);
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;

        for (int i = 0; i < 15; i++)
            step(tv[i].lk, tv[i].lb, tv[i].li, tv[i].wr, tv[i].wb, tv[i].wi, tv[i].wd,
                 0, 0, 0, tv[i].et, tv[i].erg, tv[i].nm);
        idle(5);
        chk("hold_out_valid", 32'(out_valid), 0);
        chk("hold_rgb", 32'({red, green, blue}), 32'(12'hABC));

        // Hit flash: trigger then eight frame ticks.
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "");
        idle(1);
        chk("flash_after_trig", 32'(flash_active), 32'(exp_fa[0]));
        for (int p = 1; p <= 8; p++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "");
            idle(1);
            chk($sformatf("flash_pulse%0d", p), 32'(flash_active), 32'(exp_fa[p]));
            look(3'(p % 4), 4'd1, $sformatf("flash_pix%0d", p));
            look(3'(p % 4), 4'd0, $sformatf("flash_key%0d", p));
            idle(3);
        end

        // Trigger coincident with frame_start while the count is 3.
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "");
        repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "");
        idle(1);
        chk("cnt3_active", 32'(flash_active), 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, "");
        idle(1);
        chk("coincide_load", 32'(flash_active), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "");
        idle(1);
        chk("coincide_cnt7", 32'(flash_active), 1);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "");
        idle(1);
        chk("coincide_cnt5", 32'(flash_active), 1);
        repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "");
        idle(1);
        chk("flash_expired", 32'(flash_active), 0);

        // Reset asserted with pixels in flight and flash on.
        step(0, 0, 0, 1, 3, 9, 12'h5A5, 0, 0, 0, 0, 0, "");
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "");
        idle(1);
        chk("pre_rst_flash", 32'(flash_active), 1);
        look(3, 9, "inflight0");
        look(0, 1, "inflight1");
        look(1, 2, "inflight2");
        chk("pre_rst_out_valid", 32'(out_valid), 1);
        #2;
        Reset_n = 1'b0;
        q.delete();
        pix_valid = 0; wr_en = 0; frame_start = 0; flash_trig = 0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_rgb", 32'({red, green, blue}), 0);
        chk("midrst_transp", 32'(out_transparent), 0);
        chk("midrst_flash", 32'(flash_active), 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        model_reset();
        look(3, 9, "post_rst_b3_idx9");
        look(2, 5, "post_rst_b2_idx5");
        idle(4);

        // Back-to-back stream with random writes and flash activity.
        for (int i = 0; i < 64; i++)
            step(1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)), 12'($urandom),
                 (i == 20), (i % 6 == 5), 1, 0, 0, $sformatf("stream%0d", i));
        idle(4);

        for (int w = 0; w < 10 && q.size() != 0; w++) idle(1);
        chk("drain_queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
